// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and memory bus signals of the load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_mask;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  modport slave (
    input  req_valid, req_wen, req_mask, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport master (
    output req_valid, req_wen, req_mask, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine with alignment check, lane steering and load extension
module load_store_unit (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave lsu
);
  localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        wen_q, wen_d, fault_q, fault_d;
  logic [2:0]  mask_q, mask_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, sh, ext;
  logic        accept, bad;
  always_comb begin
    accept  = state_q == IDLE && lsu.req_valid;
    bad     = (lsu.req_mask[1] & lsu.req_mask[0]) | (lsu.req_mask[2] & lsu.req_mask[1])
            | (lsu.req_mask[1:0] == 2'b01 & lsu.req_addr[0])
            | (lsu.req_mask[1:0] == 2'b10 & |lsu.req_addr[1:0]);
    sh      = lsu.mem_rdata >> {off_q, 3'b000};
    ext     = mask_q[1] ? sh
            : mask_q[0] ? {{16{sh[15] & ~mask_q[2]}}, sh[15:0]}
            : {{24{sh[7] & ~mask_q[2]}}, sh[7:0]};
    state_d = state_q == IDLE ? (lsu.req_valid ? (bad ? RESP : BUS) : IDLE)
            : state_q == BUS  ? (lsu.mem_gnt ? (wen_q ? RESP : WAIT) : BUS)
            : state_q == WAIT ? (lsu.mem_rvalid ? RESP : WAIT)
            : IDLE;
    wen_d   = accept ? lsu.req_wen : wen_q;
    mask_d  = accept ? lsu.req_mask : mask_q;
    off_d   = accept ? lsu.req_addr[1:0] : off_q;
    addr_d  = accept ? {lsu.req_addr[31:2], 2'b00} : addr_q;
    fault_d = accept ? bad : fault_q;
    be_d    = !accept ? be_q
            : lsu.req_mask[1] ? 4'b1111
            : lsu.req_mask[0] ? 4'b0011 << lsu.req_addr[1:0]
            : 4'b0001 << lsu.req_addr[1:0];
    wdata_d = !accept ? wdata_q
            : !lsu.req_wen ? 32'd0
            : lsu.req_mask[1] ? lsu.req_wdata
            : lsu.req_mask[0] ? {2{lsu.req_wdata[15:0]}}
            : {4{lsu.req_wdata[7:0]}};
    rdata_d = accept ? 32'd0 : (state_q == WAIT && lsu.mem_rvalid) ? ext : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      fault_q <= 1'b0;
      mask_q  <= 3'd0;
      off_q   <= 2'd0;
      be_q    <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      fault_q <= fault_d;
      mask_q  <= mask_d;
      off_q   <= off_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign lsu.req_ready  = state_q == IDLE;
  assign lsu.resp_valid = state_q == RESP;
  assign lsu.resp_fault = state_q == RESP && fault_q;
  assign lsu.resp_rdata = rdata_q;
  assign lsu.mem_req    = state_q == BUS;
  assign lsu.mem_we     = state_q == BUS && wen_q;
  assign lsu.mem_be     = state_q == BUS ? be_q : 4'd0;
  assign lsu.mem_addr   = addr_q;
  assign lsu.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized load/store requests checked against a byte-level reference model
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  load_store_unit_if bus ();
  load_store_unit dut (.clk(clk), .rst(rst), .lsu(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int width_of(input logic [2:0] m);
    case (m)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction
  function automatic logic [31:0] ref_load(input logic [2:0] m, input int off, input logic [31:0] word);
    int n = width_of(m);
    longint full = longint'(1) << (8 * n);
    longint v = (longint'(word) >> (8 * off)) % full;
    if (m != 3'b100 && m != 3'b101 && n < 4 && v >= full / 2) v = v - full;
    return 32'(v);
  endfunction
  function automatic logic [31:0] ref_store(input logic [2:0] m, input logic [31:0] wd);
    int n = width_of(m);
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++) r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction
  task automatic reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_be"}, 32'(bus.mem_be), 32'd0);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_fault"}, 32'(bus.resp_fault), 32'd0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
  endtask
  task automatic do_req(input logic wen, input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rword, input int gd, input int rd);
    int n = width_of(m);
    bit flt = (n == 0) || (int'(a[1:0]) % (n == 0 ? 1 : n) != 0);
    int early = 0;
    int reqs = 0;
    logic [31:0] ebe = flt ? 32'd0 : ((32'd1 << n) - 1) << a[1:0];
    logic [31:0] ewd = flt || !wen ? 32'd0 : ref_store(m, wd);
    logic [31:0] erd = flt || wen ? 32'd0 : ref_load(m, int'(a[1:0]), rword);
    @(negedge clk);
    chk("ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_wen = wen;
    bus.req_mask = m;
    bus.req_addr = a;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    bus.req_addr = $urandom;
    if (flt) begin
      chk("fault_no_req", 32'(bus.mem_req), 32'd0);
    end else begin
      for (int c = 0; c <= gd; c++) begin
        chk("mem_req", 32'(bus.mem_req), 32'd1);
        chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
        chk("mem_be", 32'(bus.mem_be), ebe);
        chk("mem_we", 32'(bus.mem_we), 32'(wen));
        chk("mem_wdata", bus.mem_wdata, ewd);
        chk("busy_ready", 32'(bus.req_ready), 32'd0);
        early += int'(bus.resp_valid);
        bus.mem_rvalid = 1'($urandom);
        bus.mem_rdata = $urandom;
        bus.mem_gnt = (c == gd);
        @(negedge clk);
      end
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (!wen) begin
        for (int c = 0; c <= rd; c++) begin
          reqs += int'(bus.mem_req);
          early += int'(bus.resp_valid);
          bus.mem_rvalid = (c == rd);
          bus.mem_rdata = (c == rd) ? rword : $urandom;
          @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = $urandom;
        chk("req_after_gnt", 32'(reqs), 32'd0);
      end
    end
    chk("early_resp", 32'(early), 32'd0);
    chk("resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("resp_fault", 32'(bus.resp_fault), 32'(flt));
    chk("resp_rdata", bus.resp_rdata, erd);
    chk("resp_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("resp_pulse", 32'(bus.resp_valid), 32'd0);
  endtask
  initial begin
    logic [2:0] legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int late;
    bus.req_valid = 0; bus.req_wen = 0; bus.req_mask = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    repeat (3) @(negedge clk);
    reset_vals("rst");
    rst = 1'b0;
    do_req(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 0);
    do_req(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_8056, 0, 0);
    do_req(1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_8056, 0, 0);
    do_req(1'b0, 3'b001, 32'h0000_3002, 32'h0, 32'h8001_FFFF, 0, 3);
    do_req(1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 0, 0);
    do_req(1'b0, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 0, 0);
    do_req(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 1, 1);
    do_req(1'b1, 3'b010, 32'h0000_5000, 32'h1357_9BDF, 32'h0, 5, 0);
    do_req(1'b1, 3'b001, 32'h0000_5002, 32'h0000_BEEF, 32'h0, 2, 0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_mask = 3'b010; bus.req_addr = 32'h0000_6000;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    reset_vals("rst_wait");
    rst = 1'b0;
    late = 0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      late += int'(bus.resp_valid) + int'(bus.mem_req);
      @(negedge clk);
    end
    chk("late_rvalid", 32'(late), 32'd0);
    for (int i = 0; i < 80; i++) begin
      logic [2:0] m = ($urandom % 4 == 0) ? 3'($urandom) : legal[$urandom % 5];
      logic [31:0] a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      do_req(1'($urandom), m, a, $urandom, $urandom, int'($urandom % 4), int'($urandom % 4));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
